// File: rtl/matmul_seq_param.sv
// rtl/matmul_seq_param.sv - sequential N x N matrix multiplier, one shared MAC per enabled cycle
// Optional feature macro MATMUL_SAT_EN: widened accumulator with results clamped to the OW range.
module matmul_seq_param #(
    parameter int N      = 4,
    parameter int DW     = 8,
    parameter int OW     = 18,
    parameter int SIGNED = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 start,
    input  logic [N*N*DW-1:0]    a_flat,
    input  logic [N*N*DW-1:0]    b_flat,
    output logic [N*N*OW-1:0]    c_flat,
    output logic                 busy,
    output logic                 done
);
    localparam int IW  = $clog2(N);
    localparam int PW  = 2 * DW;
`ifdef MATMUL_SAT_EN
    localparam int AW  = 2 * DW + $clog2(N) + 1;
    localparam int XW  = AW + OW + 2;
`else
    localparam int AW  = OW;
`endif
    localparam int AOW = $clog2(N * N * DW);
    localparam int COW = $clog2(N * N * OW);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;

    logic [N*N*DW-1:0] a_reg, b_reg;
    logic [N*N*OW-1:0] c_int, c_next;
    logic [IW-1:0]     i, j, k;
    logic [AW-1:0]     acc, sum, prod_x;
    logic [PW-1:0]     a_x, b_x, prod;
    logic [DW-1:0]     a_el, b_el;
    logic [AOW-1:0]    a_off, b_off;
    logic [COW-1:0]    c_off;
    logic [OW-1:0]     c_val;
    logic              k_last, j_last, i_last, last;
`ifdef MATMUL_SAT_EN
    logic signed [XW-1:0] sum_w, hi, lo;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    assign k_last = (k == IW'(N - 1));
    assign j_last = (j == IW'(N - 1));
    assign i_last = (i == IW'(N - 1));
    assign last   = k_last && j_last && i_last;

    always_comb begin
        a_off = AOW'((int'(i) * N + int'(k)) * DW);
        b_off = AOW'((int'(k) * N + int'(j)) * DW);
        c_off = COW'((int'(i) * N + int'(j)) * OW);
        a_el  = a_reg[a_off +: DW];
        b_el  = b_reg[b_off +: DW];
        // Product truncated to 2*DW bits is exact for both signed and unsigned operands
        if (SIGNED != 0) begin
            a_x = PW'($signed(a_el));
            b_x = PW'($signed(b_el));
        end else begin
            a_x = PW'(a_el);
            b_x = PW'(b_el);
        end
        prod = a_x * b_x;
        if (SIGNED != 0) prod_x = AW'($signed(prod));
        else             prod_x = AW'(prod);
        sum = acc + prod_x;
`ifdef MATMUL_SAT_EN
        hi = '0;
        lo = '0;
        if (SIGNED != 0) begin
            sum_w          = XW'($signed(sum));
            hi[OW-2:0]     = '1;
            lo             = '1;
            lo[OW-2:0]     = '0;
        end else begin
            sum_w          = XW'(sum);
            hi[OW-1:0]     = '1;
        end
        if (sum_w > hi)      c_val = hi[OW-1:0];
        else if (sum_w < lo) c_val = lo[OW-1:0];
        else                 c_val = sum_w[OW-1:0];
`else
        c_val = sum;
`endif
        c_next = c_int;
        c_next[c_off +: OW] = c_val;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            i      <= '0;
            j      <= '0;
            k      <= '0;
            acc    <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
            c_int  <= '0;
            c_flat <= '0;
        end else if (enable) begin
            state <= state_nx;
            case (state)
                IDLE: if (start) begin
                    a_reg <= a_flat;
                    b_reg <= b_flat;
                    i     <= '0;
                    j     <= '0;
                    k     <= '0;
                    acc   <= '0;
                end
                RUN: if (k_last) begin
                    acc   <= '0;
                    k     <= '0;
                    c_int <= c_next;
                    if (j_last) begin
                        j <= '0;
                        i <= i_last ? '0 : i + IW'(1);
                    end else begin
                        j <= j + IW'(1);
                    end
                    // Publish the whole matrix at once so c_flat never shows a partial result
                    if (last) c_flat <= c_next;
                end else begin
                    acc <= sum;
                    k   <= k + IW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule
